// File: rtl/m_trap_csr_unit.sv
`default_nettype none
// ============================================================================
//  Module   : m_trap_csr_unit
//  Purpose  : Machine-mode CSR file and trap sequencer for an RV32 M-only core.
//             Holds mstatus/misa/mie/mip/mtvec/mscratch/mepc/mcause/mtval and
//             the ID CSRs, takes exceptions, interrupts and mret at commit,
//             and sends the resulting PC redirect to fetch over valid/ready.
//  Ports    : clk, rst                        - clock, sync active-high reset
//             csr_req/op/wen/addr/wdata       - CSR instruction access
//             csr_rdata, csr_illegal          - combinational read data / illegal
//             exc_valid/code/tval, cur_pc     - synchronous exception at commit
//             int_ok, irq_meip/mtip/msip      - interrupt boundary and lines
//             mret                            - mret at commit
//             redirect_valid/pc/ready         - redirect handshake to fetch
//  Revision : 1.0 - initial release
// ============================================================================
module m_trap_csr_unit #(
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
   parameter logic [31:0] HART_ID     = 32'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        csr_req,
   input  logic [1:0]  csr_op,
   input  logic        csr_wen,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic        csr_illegal,
   input  logic        exc_valid,
   input  logic [4:0]  exc_code,
   input  logic [31:0] exc_tval,
   input  logic [31:0] cur_pc,
   input  logic        int_ok,
   input  logic        irq_meip,
   input  logic        irq_mtip,
   input  logic        irq_msip,
   input  logic        mret,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready
);

   localparam logic [31:0] MISA_VAL = 32'h4000_0100;
   localparam logic [1:0]  OP_RW    = 2'b01;
   localparam logic [1:0]  OP_RS    = 2'b10;
   localparam logic [1:0]  OP_RC    = 2'b11;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      REDIRECT = 1'b1
   } state_t;

   state_t      state;
   logic        mstatus_mie;
   logic        mstatus_mpie;
   logic [31:0] mie_en;
   logic [31:0] mtvec;
   logic [31:0] mscratch;
   logic [31:0] mepc;
   logic [31:0] mcause;
   logic [31:0] mtval;

   logic [31:0] mstatus_val;
   logic [31:0] mip_val;
   logic [31:0] pending;
   logic [31:0] read_val;
   logic        addr_hit;
   logic [31:0] wval;
   logic [4:0]  irq_code;
   logic [31:0] trap_base;
   logic [31:0] irq_target;
   logic        take_exc;
   logic        take_irq;
   logic        take_mret;
   logic        do_write;

   // MPP is hard-wired to machine mode.
   assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
   assign mip_val     = {20'b0, irq_meip, 3'b0, irq_mtip, 3'b0, irq_msip, 3'b0};
   assign pending     = mip_val & mie_en;

   always_comb begin
      addr_hit = 1'b1;
      read_val = 32'h0;
      case (csr_addr)
         12'h300: read_val = mstatus_val;
         12'h301: read_val = MISA_VAL;
         12'h304: read_val = mie_en;
         12'h305: read_val = mtvec;
         12'h340: read_val = mscratch;
         12'h341: read_val = mepc;
         12'h342: read_val = mcause;
         12'h343: read_val = mtval;
         12'h344: read_val = mip_val;
         12'hF11, 12'hF12, 12'hF13: read_val = 32'h0;
         12'hF14: read_val = HART_ID;
         default: addr_hit = 1'b0;
      endcase
   end

   // Address space 0xC00-0xFFF is read-only; writing it is illegal.
   assign csr_illegal = csr_req && (csr_op != 2'b00) &&
                        (!addr_hit || ((csr_addr[11:10] == 2'b11) && csr_wen));
   assign csr_rdata   = csr_illegal ? 32'h0 : read_val;

   always_comb begin
      wval = csr_wdata;
      case (csr_op)
         OP_RS:   wval = read_val | csr_wdata;
         OP_RC:   wval = read_val & ~csr_wdata;
         default: wval = csr_wdata;
      endcase
   end

   // Interrupt source priority: external, then software, then timer.
   always_comb begin
      irq_code = 5'd7;
      if (pending[11])     irq_code = 5'd11;
      else if (pending[3]) irq_code = 5'd3;
   end

   assign trap_base  = {mtvec[31:2], 2'b00};
   assign irq_target = (mtvec[1:0] == 2'b01) ? trap_base + {25'b0, irq_code, 2'b00}
                                             : trap_base;

   assign take_exc  = (state == IDLE) && exc_valid;
   assign take_irq  = (state == IDLE) && !exc_valid && int_ok && mstatus_mie && (|pending);
   assign take_mret = (state == IDLE) && !exc_valid && !take_irq && mret;
   assign do_write  = (state == IDLE) && csr_req && (csr_op != 2'b00) && csr_wen &&
                      !csr_illegal && !exc_valid && !take_irq && !mret;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         mstatus_mie    <= 1'b0;
         mstatus_mpie   <= 1'b0;
         mie_en         <= 32'h0;
         mtvec          <= RESET_MTVEC;
         mscratch       <= 32'h0;
         mepc           <= 32'h0;
         mcause         <= 32'h0;
         mtval          <= 32'h0;
         redirect_valid <= 1'b0;
         redirect_pc    <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (take_exc) begin
                  mcause         <= {27'b0, exc_code};
                  mtval          <= exc_tval;
                  mepc           <= cur_pc & ~32'h3;
                  mstatus_mpie   <= mstatus_mie;
                  mstatus_mie    <= 1'b0;
                  redirect_pc    <= trap_base;
                  redirect_valid <= 1'b1;
                  state          <= REDIRECT;
               end else if (take_irq) begin
                  mcause         <= {1'b1, 26'b0, irq_code};
                  mtval          <= 32'h0;
                  mepc           <= cur_pc & ~32'h3;
                  mstatus_mpie   <= mstatus_mie;
                  mstatus_mie    <= 1'b0;
                  redirect_pc    <= irq_target;
                  redirect_valid <= 1'b1;
                  state          <= REDIRECT;
               end else if (take_mret) begin
                  mstatus_mie    <= mstatus_mpie;
                  mstatus_mpie   <= 1'b1;
                  redirect_pc    <= mepc;
                  redirect_valid <= 1'b1;
                  state          <= REDIRECT;
               end else if (do_write) begin
                  case (csr_addr)
                     12'h300: begin
                        mstatus_mie  <= wval[3];
                        mstatus_mpie <= wval[7];
                     end
                     12'h304: mie_en <= wval & 32'h0000_0888;
                     // Reserved MODE encodings leave the current MODE in place.
                     12'h305: mtvec <= wval[1] ? {wval[31:2], mtvec[1:0]} : wval;
                     12'h340: mscratch <= wval;
                     12'h341: mepc <= wval & ~32'h3;
                     12'h342: mcause <= wval & 32'h8000_000F;
                     12'h343: mtval <= wval;
                     default: ;
                  endcase
               end
            end
            REDIRECT: begin
               if (redirect_ready) begin
                  redirect_valid <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
